divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 12 +
 rtl/fulladder.sv | 13 +
 rtl/subtracter.sv | 28 ++
 rtl/divider.sv | 130 +++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and default operand width for the divider
package divider_pkg;

  localparam int DIVIDER_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder cell used by the ripple subtracter
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/subtracter.sv
// rtl/subtracter.sv - W-bit ripple subtract (i_a - i_b) built from fulladder cells
module subtracter #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  logic [W:0] w_carry;

  // Two's-complement subtract: invert B and inject a carry of one at the LSB.
  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < W; g++) begin : g_bit
    fulladder u_fa (
      .i_a    (i_a[g]),
      .i_b    (~i_b[g]),
      .i_cin  (w_carry[g]),
      .o_sum  (o_diff[g]),
      .o_cout (w_carry[g+1])
    );
  end

  assign o_borrow = ~w_carry[W];

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - restoring unsigned divider, one quotient bit per cycle, MSB first
// Optional macro DIVIDER_DIVZERO_EN: divide-by-zero short cut to FIN with DivZero flag.
module divider
  import divider_pkg::*;
#(
  parameter int N = DIVIDER_WIDTH
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         Busy,
  output logic         Done,
  output logic         DivZero
);

  localparam int CW = $clog2(N + 1);

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_count;
  logic [N-1:0]   r_rem;
  logic [N-1:0]   r_dvd;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_r;

  logic [N:0]     w_shift;
  logic [N:0]     w_diff;
  logic           w_borrow;
  logic           w_keep;
  logic [N-1:0]   w_rem_next;
  logic [N-1:0]   w_q_next;
  logic           w_accept;
  logic           w_last;
  logic           w_zero_skip;

  assign w_shift = {r_rem, r_dvd[N-1]};

  subtracter #(.W(N + 1)) u_sub (
    .i_a      (w_shift),
    .i_b      ({1'b0, r_b}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // A kept remainder is always below B, so its top trial bit is zero.
  assign w_keep     = ~w_borrow & ~w_diff[N];
  assign w_rem_next = w_keep ? w_diff[N-1:0] : w_shift[N-1:0];
  assign w_q_next   = {r_dvd[N-2:0], w_keep};

`ifdef DIVIDER_DIVZERO_EN
  logic r_divzero;
  assign w_zero_skip = (B == '0);
  assign DivZero     = r_divzero;
`else
  assign w_zero_skip = 1'b0;
  assign DivZero     = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_accept = 1'b1;
          w_next   = w_zero_skip ? FIN : RUN;
        end
      end
      RUN: begin
        if (r_count == CW'(1)) begin
          w_last = 1'b1;
          w_next = FIN;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_r     <= '0;
`ifdef DIVIDER_DIVZERO_EN
      r_divzero <= 1'b0;
`endif
    end else if (w_accept) begin
      r_b     <= B;
      r_dvd   <= A;
      r_rem   <= '0;
      r_count <= CW'(N);
`ifdef DIVIDER_DIVZERO_EN
      r_divzero <= w_zero_skip;
      if (w_zero_skip) begin
        r_q <= '1;
        r_r <= A;
      end
`endif
    end else if (r_state == RUN) begin
      r_rem   <= w_rem_next;
      r_dvd   <= w_q_next;
      r_count <= r_count - CW'(1);
      if (w_last) begin
        r_q <= w_q_next;
        r_r <= w_rem_next;
      end
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign Busy = (r_state != IDLE);
  assign Done = (r_state == FIN);

endmodule
